// File: rtl/sha256_stream_core.sv
// sha256_stream_core
//   Multi-block SHA-256 / SHA-224 compression core with a valid/ready block stream.
//   Blocks arrive already padded. The chaining value H is carried from block to block,
//   and the digest is presented once the block flagged blk_last has been compressed.
//   UNROLL rounds (1, 2 or 4) are evaluated per clock in a combinational chain.
//
// Parameters
//   MODE_224  0: SHA-256 IV and full digest; 1: SHA-224 IV, digest[31:0] forced to 0
//   UNROLL    rounds per clock (1, 2 or 4)
//   COUNT_W   block_count width
//
// Ports
//   clk, rst                  clock, synchronous active-high reset
//   blk_valid/blk_ready       block handshake; blk_data W0 in [511:480] ... W15 in [31:0]
//   blk_last                  marks the final block of a message
//   digest_valid/digest_ready digest handshake; digest H0 in [255:224] ... H7 in [31:0]
//   busy                      core is not in IDLE
//   block_count               blocks accepted in the current message (saturating)
//
// Optional feature: define SHA256_MIDSTATE_EN to add iv_load/iv_in, which seed the
// chaining value at the start of a message (e.g. a precomputed midstate).

module sha256_stream_core #(
  parameter int MODE_224 = 0,
  parameter int UNROLL   = 1,
  parameter int COUNT_W  = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               blk_valid,
  output logic               blk_ready,
  input  logic [511:0]       blk_data,
  input  logic               blk_last,
  output logic               digest_valid,
  input  logic               digest_ready,
  output logic [255:0]       digest,
  output logic               busy,
  output logic [COUNT_W-1:0] block_count
`ifdef SHA256_MIDSTATE_EN
  ,
  input  logic               iv_load,
  input  logic [255:0]       iv_in
`endif
);

  if (!(UNROLL == 1 || UNROLL == 2 || UNROLL == 4)) begin : g_bad_unroll
    $error("sha256_stream_core: UNROLL must be 1, 2 or 4");
  end

  localparam logic [255:0] IV = (MODE_224 != 0) ?
    256'hc1059ed8_367cd507_3070dd17_f70e5939_ffc00b31_68581511_64f98fa7_befa4fa4 :
    256'h6a09e667_bb67ae85_3c6ef372_a54ff53a_510e527f_9b05688c_1f83d9ab_5be0cd19;

  localparam logic [31:0] K [64] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };

  typedef enum logic [1:0] {IDLE, ROUND, UPDATE} state_e;

  function automatic logic [31:0] ror(input logic [31:0] x, input int n);
    return (x >> n) | (x << (32 - n));
  endfunction

  // One round. s = {a,b,c,d,e,f,g,h}; w = 16-word window, current W[t] in [511:480].
  // Returns {next working state, window shifted by one with W[t+16] appended}.
  function automatic logic [767:0] round_f(input logic [255:0] s, input logic [511:0] w,
                                           input logic [31:0] k);
    logic [31:0] a, b, c, d, e, f, g, h, t1, t2, wn;
    {a, b, c, d, e, f, g, h} = s;
    t1 = h + (ror(e, 6) ^ ror(e, 11) ^ ror(e, 25)) + ((e & f) ^ (~e & g)) + k + w[511:480];
    t2 = (ror(a, 2) ^ ror(a, 13) ^ ror(a, 22)) + ((a & b) ^ (a & c) ^ (b & c));
    // w[14] at [63:32], w[9] at [223:192], w[1] at [479:448], w[0] at [511:480]
    wn = (ror(w[63:32], 17) ^ ror(w[63:32], 19) ^ (w[63:32] >> 10)) + w[223:192] +
         (ror(w[479:448], 7) ^ ror(w[479:448], 18) ^ (w[479:448] >> 3)) + w[511:480];
    return {t1 + t2, a, b, c, d + t1, e, f, g, w[479:0], wn};
  endfunction

  state_e               state_q, state_d;
  logic [255:0]         h_q, h_d, v_q, v_d, dig_q, dig_d;
  logic [511:0]         w_q, w_d;
  logic [5:0]           rnd_q, rnd_d;
  logic                 last_q, last_d, new_msg_q, new_msg_d, dv_q, dv_d;
  logic [COUNT_W-1:0]   cnt_q, cnt_d;
  logic [255:0]         h_seed, h_upd;

  // Unrolled round chain: stage u+1 is round rnd_q+u applied to stage u.
  logic [255:0] st [UNROLL+1];
  logic [511:0] wt [UNROLL+1];
  assign st[0] = v_q;
  assign wt[0] = w_q;
  for (genvar u = 0; u < UNROLL; u++) begin : g_rnd
    assign {st[u+1], wt[u+1]} = round_f(st[u], wt[u], K[rnd_q + 6'(u)]);
  end

  always_comb begin
    h_upd = '0;
    for (int i = 0; i < 8; i++) h_upd[32*i +: 32] = h_q[32*i +: 32] + v_q[32*i +: 32];
  end

  assign blk_ready    = (state_q == IDLE) && !dv_q && !rst;
  assign busy         = (state_q != IDLE) && !rst;
  assign digest_valid = dv_q;
  assign digest       = dig_q;
  assign block_count  = cnt_q;

  always_comb begin
    state_d   = state_q;
    h_d       = h_q;
    v_d       = v_q;
    w_d       = w_q;
    rnd_d     = rnd_q;
    last_d    = last_q;
    new_msg_d = new_msg_q;
    dv_d      = dv_q;
    dig_d     = dig_q;
    cnt_d     = cnt_q;
    h_seed    = h_q;
`ifdef SHA256_MIDSTATE_EN
    // Seeding only at a message boundary with nothing pending; a block accepted on
    // the same edge compresses from the loaded value.
    if (state_q == IDLE && new_msg_q && !dv_q && iv_load) begin
      h_seed = iv_in;
      h_d    = iv_in;
    end
`endif
    if (dv_q && digest_ready) dv_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (blk_valid && blk_ready) begin
          state_d = ROUND;
          w_d     = blk_data;
          v_d     = h_seed;
          rnd_d   = '0;
          last_d  = blk_last;
          if (new_msg_q)         cnt_d = COUNT_W'(1);
          else if (cnt_q != '1)  cnt_d = cnt_q + COUNT_W'(1);
        end
      end
      ROUND: begin
        v_d   = st[UNROLL];
        w_d   = wt[UNROLL];
        rnd_d = rnd_q + 6'(UNROLL);
        if (rnd_q == 6'(64 - UNROLL)) state_d = UPDATE;
      end
      UPDATE: begin
        state_d = IDLE;
        if (last_q) begin
          dig_d     = (MODE_224 != 0) ? {h_upd[255:32], 32'h0} : h_upd;
          dv_d      = 1'b1;
          h_d       = IV;
          new_msg_d = 1'b1;
        end else begin
          h_d       = h_upd;
          new_msg_d = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      h_q       <= IV;
      v_q       <= '0;
      w_q       <= '0;
      rnd_q     <= '0;
      last_q    <= 1'b0;
      new_msg_q <= 1'b1;
      dv_q      <= 1'b0;
      dig_q     <= '0;
      cnt_q     <= '0;
    end else begin
      state_q   <= state_d;
      h_q       <= h_d;
      v_q       <= v_d;
      w_q       <= w_d;
      rnd_q     <= rnd_d;
      last_q    <= last_d;
      new_msg_q <= new_msg_d;
      dv_q      <= dv_d;
      dig_q     <= dig_d;
      cnt_q     <= cnt_d;
    end
  end

endmodule

// File: tb/tb_sha256_stream_core.sv
// Bench for sha256_stream_core: three instances (UNROLL 1/4/2, the last in SHA-224 mode
// with a 2-bit block counter). Digests are checked through per-instance scoreboard queues.
module tb_sha256_stream_core;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [2:0]   bv, rdy, dv, bsy;
  logic [511:0] bdata;
  logic         blast, dready;
  logic [255:0] dg [3];
  logic [15:0]  c0, c1;
  logic [1:0]   c2;
  logic         ivl;
  logic [255:0] ivin;

  int cyc = 0;
  int ncmp = 0;
  int nerr = 0;
  always @(posedge clk) cyc <= cyc + 1;

  localparam logic [255:0] IV256 = 256'h6a09e667_bb67ae85_3c6ef372_a54ff53a_510e527f_9b05688c_1f83d9ab_5be0cd19;
  localparam logic [255:0] IV224 = 256'hc1059ed8_367cd507_3070dd17_f70e5939_ffc00b31_68581511_64f98fa7_befa4fa4;
  localparam logic [511:0] ABC   = {32'h61626380, {14{32'h0}}, 32'h00000018};
  localparam logic [511:0] TWO1  = {32'h61626364, 32'h62636465, 32'h63646566, 32'h64656667,
                                    32'h65666768, 32'h66676869, 32'h6768696a, 32'h68696a6b,
                                    32'h696a6b6c, 32'h6a6b6c6d, 32'h6b6c6d6e, 32'h6c6d6e6f,
                                    32'h6d6e6f70, 32'h6e6f7071, 32'h80000000, 32'h00000000};
  localparam logic [511:0] TWO2  = {{15{32'h0}}, 32'h000001c0};
  localparam logic [255:0] D_ABC = 256'hba7816bf_8f01cfea_414140de_5dae2223_b00361a3_96177a9c_b410ff61_f20015ad;
  localparam logic [255:0] D_TWO = 256'h248d6a61_d20638b8_e5c02693_0c3e6039_a33ce459_64ff2167_f6ecedd4_19db06c1;
  localparam logic [255:0] D_224 = 256'h23097d22_3405d822_8642a477_bda255b3_2aadbce4_bda0b3f7_e36c9da7_00000000;

  localparam logic [31:0] KT [64] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };

  sha256_stream_core #(.MODE_224(0), .UNROLL(1), .COUNT_W(16)) u0 (
    .clk(clk), .rst(rst), .blk_valid(bv[0]), .blk_ready(rdy[0]), .blk_data(bdata), .blk_last(blast),
    .digest_valid(dv[0]), .digest_ready(dready), .digest(dg[0]), .busy(bsy[0]), .block_count(c0)
`ifdef SHA256_MIDSTATE_EN
    , .iv_load(ivl), .iv_in(ivin)
`endif
  );
  sha256_stream_core #(.MODE_224(0), .UNROLL(4), .COUNT_W(16)) u1 (
    .clk(clk), .rst(rst), .blk_valid(bv[1]), .blk_ready(rdy[1]), .blk_data(bdata), .blk_last(blast),
    .digest_valid(dv[1]), .digest_ready(dready), .digest(dg[1]), .busy(bsy[1]), .block_count(c1)
`ifdef SHA256_MIDSTATE_EN
    , .iv_load(1'b0), .iv_in(256'h0)
`endif
  );
  sha256_stream_core #(.MODE_224(1), .UNROLL(2), .COUNT_W(2)) u2 (
    .clk(clk), .rst(rst), .blk_valid(bv[2]), .blk_ready(rdy[2]), .blk_data(bdata), .blk_last(blast),
    .digest_valid(dv[2]), .digest_ready(dready), .digest(dg[2]), .busy(bsy[2]), .block_count(c2)
`ifdef SHA256_MIDSTATE_EN
    , .iv_load(1'b0), .iv_in(256'h0)
`endif
  );

  // Reference compression with a full 64-word schedule.
  function automatic logic [31:0] ror(input logic [31:0] x, input int n);
    return (x >> n) | (x << (32 - n));
  endfunction
  function automatic logic [255:0] model(input logic [255:0] hin, input logic [511:0] blk);
    logic [31:0] w [64];
    logic [31:0] a, b, c, d, e, f, g, h, t1, t2;
    for (int t = 0; t < 16; t++) w[t] = blk[511 - 32*t -: 32];
    for (int t = 16; t < 64; t++)
      w[t] = (ror(w[t-2], 17) ^ ror(w[t-2], 19) ^ (w[t-2] >> 10)) + w[t-7] +
             (ror(w[t-15], 7) ^ ror(w[t-15], 18) ^ (w[t-15] >> 3)) + w[t-16];
    {a, b, c, d, e, f, g, h} = hin;
    for (int t = 0; t < 64; t++) begin
      t1 = h + (ror(e, 6) ^ ror(e, 11) ^ ror(e, 25)) + ((e & f) ^ (~e & g)) + KT[t] + w[t];
      t2 = (ror(a, 2) ^ ror(a, 13) ^ ror(a, 22)) + ((a & b) ^ (a & c) ^ (b & c));
      h = g; g = f; f = e; e = d + t1; d = c; c = b; b = a; a = t1 + t2;
    end
    return {a + hin[255:224], b + hin[223:192], c + hin[191:160], d + hin[159:128],
            e + hin[127:96],  f + hin[95:64],   g + hin[63:32],   h + hin[31:0]};
  endfunction

  typedef struct { logic [255:0] dig; int cnt; } exp_t;
  exp_t q0[$], q1[$], q2[$];

  task automatic cmp(input string nm, input logic [255:0] got, input logic [255:0] exp);
    ncmp++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s got=%h want=%h", nm, got, exp);
    end
  endtask

  task automatic push(input int k, input logic [255:0] d, input int c);
    exp_t e;
    e.dig = d; e.cnt = c;
    case (k)
      0: q0.push_back(e);
      1: q1.push_back(e);
      default: q2.push_back(e);
    endcase
  endtask

  task automatic pop_chk(input int k, input logic [255:0] got, input int gc);
    exp_t e;
    bit have;
    have = 0;
    case (k)
      0: if (q0.size() > 0) begin e = q0.pop_front(); have = 1; end
      1: if (q1.size() > 0) begin e = q1.pop_front(); have = 1; end
      default: if (q2.size() > 0) begin e = q2.pop_front(); have = 1; end
    endcase
    if (!have) begin
      ncmp++; nerr++;
      $display("FAIL unexpected_digest dut%0d got=%h", k, got);
    end else begin
      cmp($sformatf("digest_dut%0d", k), got, e.dig);
      cmp($sformatf("block_count_dut%0d", k), 256'(gc), 256'(e.cnt));
    end
  endtask

  // Scoreboard side: digest handshakes pop and compare.
  always @(negedge clk) begin
    if (!rst && dready) begin
      if (dv[0]) pop_chk(0, dg[0], int'(c0));
      if (dv[1]) pop_chk(1, dg[1], int'(c1));
      if (dv[2]) pop_chk(2, dg[2], int'(c2));
    end
  end

  task automatic send(input int k, input logic [511:0] d, input logic l, output int acc);
    int n;
    n = 0;
    acc = -1;
    @(posedge clk); #1;
    while (!rdy[k] && n < 400) begin @(posedge clk); #1; n++; end
    if (!rdy[k]) begin
      ncmp++; nerr++;
      $display("FAIL send_timeout dut%0d ready=0 after %0d cycles, want 1", k, n);
    end else begin
      bdata = d; blast = l; bv[k] = 1'b1;
      @(posedge clk); #1;
      acc = cyc;
      bv[k] = 1'b0;
    end
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((q0.size() + q1.size() + q2.size()) != 0 && n < 3000) begin @(posedge clk); n++; end
    if ((q0.size() + q1.size() + q2.size()) != 0) begin
      ncmp++; nerr++;
      $display("FAIL drain_timeout pending=%0d want 0", q0.size() + q1.size() + q2.size());
    end
    @(posedge clk); #1;
  endtask

  typedef struct {
    int               k;
    int               nb;
    logic [3:0][511:0] b;
    logic [255:0]     dig;
    int               cnt;
  } vec_t;
  vec_t vt [7];

  initial begin
    int acc, lat, n;
    logic [255:0] h;
    logic [511:0] rb;
    bv = '0; bdata = '0; blast = 1'b0; dready = 1'b1; ivl = 1'b0; ivin = '0;

    // Reset state
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    cmp("rst_blk_ready", 256'(rdy), 256'(0));
    cmp("rst_digest_valid", 256'(dv), 256'(0));
    cmp("rst_busy", 256'(bsy), 256'(0));
    cmp("rst_block_count", 256'(c0), 256'(0));
    cmp("rst_digest", dg[0], 256'h0);
    rst = 1'b0;
    #1;
    cmp("post_rst_ready", 256'(rdy), 256'(3'b111));

    // Vector table
    vt[0] = '{k: 0, nb: 1, b: {3{512'h0}} , dig: D_ABC, cnt: 1};
    vt[0].b[0] = ABC;
    vt[1] = '{k: 0, nb: 2, b: '0, dig: D_TWO, cnt: 2};
    vt[1].b[0] = TWO1; vt[1].b[1] = TWO2;
    vt[2] = '{k: 0, nb: 1, b: '0, dig: D_ABC, cnt: 1};
    vt[2].b[0] = ABC;
    vt[3] = '{k: 1, nb: 1, b: '0, dig: D_ABC, cnt: 1};
    vt[3].b[0] = ABC;
    vt[4] = '{k: 2, nb: 1, b: '0, dig: D_224, cnt: 1};
    vt[4].b[0] = ABC;
    // 4-block SHA-224 message: count saturates at 3 with a 2-bit counter
    vt[5] = '{k: 2, nb: 4, b: '0, dig: '0, cnt: 3};
    h = IV224;
    for (int i = 0; i < 4; i++) begin
      for (int j = 0; j < 16; j++) rb[511 - 32*j -: 32] = $urandom;
      vt[5].b[i] = rb;
      h = model(h, rb);
    end
    vt[5].dig = {h[255:32], 32'h0};
    vt[6] = '{k: 1, nb: 2, b: '0, dig: '0, cnt: 2};
    h = IV256;
    for (int i = 0; i < 2; i++) begin
      for (int j = 0; j < 16; j++) rb[511 - 32*j -: 32] = $urandom;
      vt[6].b[i] = rb;
      h = model(h, rb);
    end
    vt[6].dig = h;

    for (int v = 0; v < 7; v++) begin
      for (int b = 0; b < vt[v].nb; b++) begin
        if (b == vt[v].nb - 1) push(vt[v].k, vt[v].dig, vt[v].cnt);
        send(vt[v].k, vt[v].b[b], b == vt[v].nb - 1, acc);
      end
    end
    drain();

    // Latency accept edge -> first digest_valid cycle: 64/UNROLL + 1
    for (int k = 0; k < 3; k++) begin
      push(k, (k == 2) ? D_224 : D_ABC, 1);
      send(k, ABC, 1'b1, acc);
      n = 0;
      @(negedge clk);
      while (!dv[k] && n < 200) begin @(negedge clk); n++; end
      lat = cyc - acc;
      cmp($sformatf("latency_dut%0d", k), 256'(lat), 256'((k == 0) ? 65 : (k == 1) ? 17 : 33));
    end
    drain();

    // Digest back-pressure with a block waiting
    dready = 1'b0;
    push(0, D_ABC, 1);
    send(0, ABC, 1'b1, acc);
    n = 0;
    while (!dv[0] && n < 200) begin @(posedge clk); #1; n++; end
    bdata = ABC; blast = 1'b1; bv[0] = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      cmp("stall_blk_ready", 256'(rdy[0]), 256'(0));
      cmp("stall_digest_valid", 256'(dv[0]), 256'(1));
      cmp("stall_digest", dg[0], D_ABC);
    end
    dready = 1'b1;
    @(posedge clk); #1;
    cmp("release_valid_drop", 256'(dv[0]), 256'(0));
    cmp("release_not_accepted", 256'(bsy[0]), 256'(0));
    push(0, D_ABC, 1);
    @(posedge clk); #1;
    cmp("release_accept_next", 256'(bsy[0]), 256'(1));
    bv[0] = 1'b0;
    drain();

    // Reset at round 30 of block 1 of the two-block message, then a fresh "abc"
    send(0, TWO1, 1'b0, acc);
    cmp("midmsg_count", 256'(c0), 256'(1));
    repeat (30) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    cmp("abort_busy", 256'(bsy[0]), 256'(0));
    cmp("abort_count", 256'(c0), 256'(0));
    rst = 1'b0;
    push(0, D_ABC, 1);
    send(0, ABC, 1'b1, acc);
    drain();

`ifdef SHA256_MIDSTATE_EN
    // Resume the two-block message from its block-1 midstate
    ivin = model(IV256, TWO1);
    ivl = 1'b1;
    push(0, D_TWO, 1);
    send(0, TWO2, 1'b1, acc);
    ivl = 1'b0;
    drain();
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout reached, want finish earlier");
    $fatal(1, "timeout");
  end
endmodule
